// File: rtl/seg_click_pkg.sv
// Shared constants for the segment click editor: hit rectangles, digit codes, FSM states.
package seg_click_pkg;

  localparam int NUM_SEG = 7;

  // Inclusive hit rectangles, element i = segment i (a..g).
  localparam logic [6:0][7:0] SEG_X_LO = {8'd9,  8'd9,  8'd9,  8'd9,  8'd27, 8'd27, 8'd9};
  localparam logic [6:0][7:0] SEG_X_HI = {8'd29, 8'd11, 8'd11, 8'd29, 8'd29, 8'd29, 8'd29};
  localparam logic [6:0][6:0] SEG_Y_LO = {7'd26, 7'd4,  7'd29, 7'd45, 7'd29, 7'd4,  7'd4};
  localparam logic [6:0][6:0] SEG_Y_HI = {7'd28, 7'd27, 7'd47, 7'd47, 7'd47, 7'd27, 7'd6};

  // gfedcba patterns, element d = digit d.
  localparam logic [9:0][6:0] DIGIT_CODE = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIT_TEST,
    ST_COMMIT,
    ST_LOCKOUT
  } state_t;

  typedef enum logic {
    OP_LEFT,
    OP_RIGHT
  } op_t;

  function automatic logic [3:0] decode_digit(input logic [6:0] seg);
    logic [3:0] result;
    result = DIGIT_NONE;
    for (int k = 0; k < 10; k++) begin
      if (seg == DIGIT_CODE[k]) result = 4'(k);
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_click_editor_if.sv
// Mouse/cursor inputs and segment-state outputs of the click editor.
interface seg_click_editor_if;
  logic       left_btn;
  logic       right_btn;
  logic [7:0] x_cursor;
  logic [6:0] y_cursor;
  logic       clear;
  logic [6:0] seg_state;
  logic       hit_valid;
  logic [2:0] hit_index;
  logic [3:0] digit;
  logic [6:0] hover_mask;

  modport master (
    output left_btn, right_btn, x_cursor, y_cursor, clear,
    input  seg_state, hit_valid, hit_index, digit, hover_mask
  );

  modport slave (
    input  left_btn, right_btn, x_cursor, y_cursor, clear,
    output seg_state, hit_valid, hit_index, digit, hover_mask
  );
endinterface

// File: rtl/seg_hit_test.sv
// Combinational hit test of a cursor against the seven segment rectangles;
// overlapping rectangles resolve to the lowest segment index.
module seg_hit_test
  import seg_click_pkg::*;
(
  input  logic [7:0] i_x,
  input  logic [6:0] i_y,
  output logic       o_hit,
  output logic [2:0] o_index
);

  logic [NUM_SEG-1:0] w_inside;

  generate
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_rect
      assign w_inside[gi] = (i_x >= SEG_X_LO[gi]) && (i_x <= SEG_X_HI[gi]) &&
                            (i_y >= SEG_Y_LO[gi]) && (i_y <= SEG_Y_HI[gi]);
    end
  endgenerate

  always_comb begin
    o_hit   = 1'b0;
    o_index = 3'd0;
    for (int k = NUM_SEG - 1; k >= 0; k--) begin
      if (w_inside[k]) begin
        o_hit   = 1'b1;
        o_index = 3'(k);
      end
    end
  end

endmodule

// File: rtl/seg_click_editor.sv
// Mouse-driven seven-segment editor: left click toggles, right click clears a segment.
// Optional live hover highlight is enabled by defining SEG_CLICK_HOVER_EN.
module seg_click_editor
  import seg_click_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_click_editor_if.slave   bus
);

  state_t           r_state;
  op_t              r_op;
  logic             r_left_prev;
  logic             r_right_prev;
  logic [7:0]       r_x;
  logic [6:0]       r_y;
  logic             r_hit;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_seg;
  logic             r_hit_valid;
  logic [2:0]       r_hit_index;
  logic [3:0]       r_digit;

  logic             w_lpress;
  logic             w_rpress;
  logic             w_hit;
  logic [2:0]       w_idx;

  assign w_lpress = bus.left_btn  & ~r_left_prev;
  assign w_rpress = bus.right_btn & ~r_right_prev;

  seg_hit_test u_hit_latched (
    .i_x     (r_x),
    .i_y     (r_y),
    .o_hit   (w_hit),
    .o_index (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_LEFT;
      r_left_prev  <= 1'b0;
      r_right_prev <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_hit        <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_seg        <= '0;
      r_hit_valid  <= 1'b0;
      r_hit_index  <= '0;
      r_digit      <= DIGIT_NONE;
    end else begin
      r_left_prev  <= bus.left_btn;
      r_right_prev <= bus.right_btn;
      r_hit_valid  <= 1'b0;
      r_digit      <= decode_digit(r_seg);
      // clear overrides everything, including a press edge in the same cycle
      if (bus.clear) begin
        r_seg   <= '0;
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_lpress || w_rpress) begin
              r_x     <= bus.x_cursor;
              r_y     <= bus.y_cursor;
              r_op    <= w_lpress ? OP_LEFT : OP_RIGHT;
              r_state <= ST_HIT_TEST;
            end
          end
          ST_HIT_TEST: begin
            r_hit   <= w_hit;
            r_idx   <= w_idx;
            r_state <= ST_COMMIT;
          end
          ST_COMMIT: begin
            if (r_hit) begin
              r_seg[r_idx] <= (r_op == OP_LEFT) ? ~r_seg[r_idx] : 1'b0;
              r_hit_valid  <= 1'b1;
              r_hit_index  <= r_idx;
            end
            r_cnt   <= CNT_W'(LOCKOUT_CYCLES);
            r_state <= ST_LOCKOUT;
          end
          ST_LOCKOUT: begin
            if (r_cnt == '0) r_state <= ST_IDLE;
            else             r_cnt   <= r_cnt - CNT_W'(1);
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.seg_state = r_seg;
  assign bus.hit_valid = r_hit_valid;
  assign bus.hit_index = r_hit_index;
  assign bus.digit     = r_digit;

`ifdef SEG_CLICK_HOVER_EN
  logic       w_hover_hit;
  logic [2:0] w_hover_idx;
  logic [6:0] r_hover;

  seg_hit_test u_hit_hover (
    .i_x     (bus.x_cursor),
    .i_y     (bus.y_cursor),
    .o_hit   (w_hover_hit),
    .o_index (w_hover_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hover <= '0;
    else        r_hover <= w_hover_hit ? (7'b1 << w_hover_idx) : 7'b0;
  end

  assign bus.hover_mask = r_hover;
`else
  assign bus.hover_mask = 7'b0;
`endif

endmodule

// File: tb/tb_seg_click_editor.sv
// Self-checking bench for seg_click_editor: directed click table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_seg_click_editor;

  localparam int L = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_click_editor_if bus();

  seg_click_editor #(.LOCKOUT_CYCLES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Rectangles and digit codes written straight from the segment layout.
  int RX_LO[7] = '{9, 27, 27, 9, 9, 9, 9};
  int RX_HI[7] = '{29, 29, 29, 29, 11, 11, 29};
  int RY_LO[7] = '{4, 4, 29, 45, 29, 4, 26};
  int RY_HI[7] = '{6, 27, 47, 47, 47, 27, 28};
  int CODES[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  function automatic int hit_of(int x, int y);
    for (int s = 0; s < 7; s++)
      if (x >= RX_LO[s] && x <= RX_HI[s] && y >= RY_LO[s] && y <= RY_HI[s]) return s;
    return -1;
  endfunction

  function automatic int digit_of(int seg);
    for (int d = 0; d < 10; d++) if (seg == CODES[d]) return d;
    return 15;
  endfunction

  // Model state: a pending commit scheduled by cycle number plus a ready-cycle gate.
  int m_seg, m_hv, m_idx, m_digit, m_hover;
  bit m_prev_l, m_prev_r, m_pend, m_pend_left;
  int m_commit_cyc, m_pend_idx, m_ready;

  task automatic model_reset();
    m_seg = 0; m_hv = 0; m_idx = 0; m_digit = 15; m_hover = 0;
    m_prev_l = 0; m_prev_r = 0; m_pend = 0; m_pend_left = 0;
    m_commit_cyc = 0; m_pend_idx = -1; m_ready = cyc;
  endtask

  task automatic model_edge();
    bit lp, rp;
    int h;
    lp = bus.left_btn && !m_prev_l;
    rp = bus.right_btn && !m_prev_r;
    m_digit = digit_of(m_seg);
    m_hv = 0;
    h = hit_of(int'(bus.x_cursor), int'(bus.y_cursor));
    m_hover = (h < 0) ? 0 : (1 << h);
    if (bus.clear) begin
      m_seg = 0; m_pend = 0; m_ready = cyc + 1;
    end else begin
      if (m_pend && m_commit_cyc == cyc) begin
        m_pend = 0;
        if (m_pend_idx >= 0) begin
          if (m_pend_left) m_seg = m_seg ^ (1 << m_pend_idx);
          else             m_seg = m_seg & ~(1 << m_pend_idx);
          m_hv = 1; m_idx = m_pend_idx;
        end
      end
      if ((lp || rp) && cyc >= m_ready) begin
        m_pend = 1; m_pend_left = lp; m_commit_cyc = cyc + 2;
        m_pend_idx = hit_of(int'(bus.x_cursor), int'(bus.y_cursor));
        m_ready = cyc + L + 4;
      end
    end
    m_prev_l = bus.left_btn;
    m_prev_r = bus.right_btn;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    chk("seg_state", int'(bus.seg_state), m_seg);
    chk("hit_valid", int'(bus.hit_valid), m_hv);
    chk("hit_index", int'(bus.hit_index), m_idx);
    chk("digit", int'(bus.digit), m_digit);
`ifdef SEG_CLICK_HOVER_EN
    chk("hover_mask", int'(bus.hover_mask), m_hover);
`else
    chk("hover_mask", int'(bus.hover_mask), 0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    cyc++;
    #1;
    check_model();
  endtask

  typedef struct {
    int         x;
    int         y;
    int         op;   // 0 left, 1 right, 2 both
    logic [6:0] seg;
    int         hv;
    int         idx;
    int         dig;
  } vec_t;

  vec_t vecs[12];

  task automatic click(input vec_t v);
    bus.left_btn = 0; bus.right_btn = 0;
    bus.x_cursor = 8'(v.x); bus.y_cursor = 7'(v.y);
    cycle(); cycle();
    bus.left_btn  = (v.op != 1);
    bus.right_btn = (v.op != 0);
    cycle();
    bus.left_btn = 0; bus.right_btn = 0;
    cycle(); cycle();
    chk("tbl_seg", int'(bus.seg_state), int'(v.seg));
    chk("tbl_hv", int'(bus.hit_valid), v.hv);
    chk("tbl_idx", int'(bus.hit_index), v.idx);
    $display("click (%0d,%0d) op=%0d -> seg=%b hv=%0d idx=%0d", v.x, v.y, v.op,
             bus.seg_state, bus.hit_valid, bus.hit_index);
    cycle();
    chk("tbl_digit", int'(bus.digit), v.dig);
    repeat (L + 4) cycle();
  endtask

  initial begin
    vecs[0]  = '{20, 5,  0, 7'b0000001, 1, 0, 15};
    vecs[1]  = '{20, 5,  0, 7'b0000000, 1, 0, 15};
    vecs[2]  = '{28, 27, 0, 7'b0000010, 1, 1, 15};
    vecs[3]  = '{50, 50, 0, 7'b0000010, 0, 1, 15};
    vecs[4]  = '{28, 40, 0, 7'b0000110, 1, 2, 1};
    vecs[5]  = '{28, 10, 1, 7'b0000100, 1, 1, 15};
    vecs[6]  = '{10, 10, 2, 7'b0100100, 1, 5, 15};
    vecs[7]  = '{28, 40, 1, 7'b0100000, 1, 2, 15};
    vecs[8]  = '{10, 10, 1, 7'b0000000, 1, 5, 15};
    vecs[9]  = '{28, 10, 0, 7'b0000010, 1, 1, 15};
    vecs[10] = '{28, 40, 0, 7'b0000110, 1, 2, 1};
    vecs[11] = '{20, 5,  0, 7'b0000111, 1, 0, 7};

    bus.left_btn = 0; bus.right_btn = 0; bus.clear = 0;
    bus.x_cursor = 0; bus.y_cursor = 0;
    model_reset();

    // Reset held, then idle with no clicks.
    repeat (3) cycle();
    chk("rst_seg", int'(bus.seg_state), 0);
    chk("rst_digit", int'(bus.digit), 15);
    chk("rst_hv", int'(bus.hit_valid), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (100) cycle();
    chk("idle_seg", int'(bus.seg_state), 0);
    chk("idle_digit", int'(bus.digit), 15);
    $display("reset/idle done: seg=%b digit=%0h", bus.seg_state, bus.digit);

    foreach (vecs[i]) click(vecs[i]);

    // Press 10 cycles after a commit lands in lockout and is dropped.
    bus.x_cursor = 28; bus.y_cursor = 10;
    cycle(); cycle();
    bus.left_btn = 1; cycle();
    bus.left_btn = 0; cycle(); cycle();
    chk("lock_first_seg", int'(bus.seg_state), 7'b0000101);
    chk("lock_first_hv", int'(bus.hit_valid), 1);
    repeat (9) cycle();
    bus.x_cursor = 20; bus.y_cursor = 5; bus.left_btn = 1;
    cycle();
    bus.left_btn = 0;
    repeat (3) cycle();
    chk("lock_drop_seg", int'(bus.seg_state), 7'b0000101);
    chk("lock_drop_hv", int'(bus.hit_valid), 0);
    $display("lockout press: seg=%b hv=%0d", bus.seg_state, bus.hit_valid);
    repeat (L + 10) cycle();

    // clear while the FSM is in HIT_TEST.
    bus.x_cursor = 20; bus.y_cursor = 5; bus.left_btn = 1;
    cycle();
    bus.left_btn = 0; bus.clear = 1;
    cycle();
    bus.clear = 0;
    chk("clr_seg", int'(bus.seg_state), 0);
    chk("clr_hv", int'(bus.hit_valid), 0);
    cycle();
    chk("clr_nopulse", int'(bus.hit_valid), 0);
    bus.x_cursor = 28; bus.y_cursor = 10; bus.left_btn = 1;
    cycle();
    bus.left_btn = 0;
    cycle(); cycle();
    chk("clr_after_seg", int'(bus.seg_state), 7'b0000010);
    chk("clr_after_hv", int'(bus.hit_valid), 1);
    chk("clr_after_idx", int'(bus.hit_index), 1);
    $display("clear in HIT_TEST: seg=%b hv=%0d", bus.seg_state, bus.hit_valid);

    // Asynchronous reset in the middle of LOCKOUT.
    repeat (3) cycle();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_seg", int'(bus.seg_state), 0);
    chk("arst_idx", int'(bus.hit_index), 0);
    chk("arst_digit", int'(bus.digit), 15);
    @(negedge clk);
    rst_n = 1;
    bus.x_cursor = 20; bus.y_cursor = 5; bus.left_btn = 1;
    cycle();
    bus.left_btn = 0;
    cycle(); cycle();
    chk("arst_press_seg", int'(bus.seg_state), 7'b0000001);
    chk("arst_press_hv", int'(bus.hit_valid), 1);
    $display("reset in LOCKOUT: seg=%b hv=%0d", bus.seg_state, bus.hit_valid);
    repeat (L + 6) cycle();

    // Randomized traffic checked every cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) bus.left_btn = ~bus.left_btn;
      if ($urandom_range(0, 5) == 0) bus.right_btn = ~bus.right_btn;
      if ($urandom_range(0, 2) == 0) begin
        bus.x_cursor = 8'($urandom_range(0, 63));
        bus.y_cursor = 7'($urandom_range(0, 55));
      end
      bus.clear = ($urandom_range(0, 149) == 0);
      cycle();
    end
    bus.clear = 0; bus.left_btn = 0; bus.right_btn = 0;
    cycle();
    $display("random phase done: seg=%b digit=%0h", bus.seg_state, bus.digit);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
